// File: rtl/xfire_fpu_bkm_host_pkg.sv
// Shared widths, encodings and FSM states for the BKM host front end.
// No logic; types and constants only.
// Imported by the host and its bench.
package xfire_fpu_bkm_host_pkg;

    localparam int OPSIZE = 4;
    localparam int FSIZE  = 5;

    // Number formats understood by the BKM core.
    typedef enum logic [1:0] {
        FMT_FP16  = 2'd0,
        FMT_FP32  = 2'd1,
        FMT_FP64  = 2'd2,
        FMT_FIXED = 2'd3
    } fmt_t;

    // Host sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/xfire_fpu_bkm_host.sv
// Purpose: accept one tagged command, run it on the BKM core, return results with tag.
// Latency: accept->core_start 1 cycle; core_done->rsp_valid 1 cycle; watchdog ends WAIT after TMO cycles.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready; enable=0 freezes everything.
module xfire_fpu_bkm_host
    import xfire_fpu_bkm_host_pkg::*;
#(
    parameter int W    = 64,
    parameter int TAGW = 4,
    parameter int TMO  = 200,
    parameter int TMW  = 8
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              srst,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_format,
    input  logic [OPSIZE-1:0] cmd_op,
    input  logic [W-1:0]      cmd_x1,
    input  logic [W-1:0]      cmd_y1,
    input  logic [W-1:0]      cmd_x2,
    input  logic [W-1:0]      cmd_y2,
    input  logic [TAGW-1:0]   cmd_tag,
    output logic              core_start,
    output logic [1:0]        core_format,
    output logic [OPSIZE-1:0] core_op,
    output logic [W-1:0]      core_x1,
    output logic [W-1:0]      core_y1,
    output logic [W-1:0]      core_x2,
    output logic [W-1:0]      core_y2,
    input  logic [W-1:0]      core_x3,
    input  logic [W-1:0]      core_y3,
    input  logic [FSIZE-1:0]  core_flags,
    input  logic              core_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_x3,
    output logic [W-1:0]      rsp_y3,
    output logic [FSIZE-1:0]  rsp_flags,
    output logic [TAGW-1:0]   rsp_tag,
    output logic              rsp_timeout,
    output logic              busy
);

    state_t          state;
    state_t          state_nxt;
    logic [TMW-1:0]  cnt;
    logic [TAGW-1:0] tag_q;
    logic            wd_last;

    // Last WAIT cycle the watchdog allows before forcing a timeout response.
    assign wd_last   = (cnt == TMW'(TMO - 1));
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    // State register; srst overrides enable.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)        state <= ST_IDLE;
        else if (srst)   state <= ST_IDLE;
        else if (enable) state <= state_nxt;
    end

    // Next-state decode plus the handshake and start strobe.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        core_start = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = enable;
                if (cmd_valid) state_nxt = ST_START;
            end
            ST_START: begin
                core_start = enable;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done || wd_last) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, watchdog count and result capture (done beats timeout).
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            core_format <= '0;
            core_op     <= '0;
            core_x1     <= '0;
            core_y1     <= '0;
            core_x2     <= '0;
            core_y2     <= '0;
            tag_q       <= '0;
            cnt         <= '0;
            rsp_x3      <= '0;
            rsp_y3      <= '0;
            rsp_flags   <= '0;
            rsp_tag     <= '0;
            rsp_timeout <= 1'b0;
        end else if (srst) begin
            core_format <= '0;
            core_op     <= '0;
            core_x1     <= '0;
            core_y1     <= '0;
            core_x2     <= '0;
            core_y2     <= '0;
            tag_q       <= '0;
            cnt         <= '0;
            rsp_x3      <= '0;
            rsp_y3      <= '0;
            rsp_flags   <= '0;
            rsp_tag     <= '0;
            rsp_timeout <= 1'b0;
        end else if (enable) begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        core_format <= cmd_format;
                        core_op     <= cmd_op;
                        core_x1     <= cmd_x1;
                        core_y1     <= cmd_y1;
                        core_x2     <= cmd_x2;
                        core_y2     <= cmd_y2;
                        tag_q       <= cmd_tag;
                    end
                end
                ST_START: cnt <= '0;
                ST_WAIT: begin
                    cnt <= cnt + TMW'(1);
                    if (core_done) begin
                        rsp_x3      <= core_x3;
                        rsp_y3      <= core_y3;
                        rsp_flags   <= core_flags;
                        rsp_tag     <= tag_q;
                        rsp_timeout <= 1'b0;
                    end else if (wd_last) begin
                        rsp_x3      <= '0;
                        rsp_y3      <= '0;
                        rsp_flags   <= '0;
                        rsp_tag     <= tag_q;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xfire_fpu_bkm_host.sv
// Bench for xfire_fpu_bkm_host: directed scenarios plus randomized transactions.
// Expected results come from a transaction-level model of the host contract.
// Core is emulated by the bench with a chosen done cycle per command.
module tb_xfire_fpu_bkm_host;
    import xfire_fpu_bkm_host_pkg::*;

    localparam int W    = 64;
    localparam int TAGW = 4;
    localparam int TMO  = 16;
    localparam int TMW  = 8;

    logic              clk = 1'b0;
    logic              arst, srst, enable;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_format;
    logic [OPSIZE-1:0] cmd_op;
    logic [W-1:0]      cmd_x1, cmd_y1, cmd_x2, cmd_y2;
    logic [TAGW-1:0]   cmd_tag;
    logic              core_start;
    logic [1:0]        core_format;
    logic [OPSIZE-1:0] core_op;
    logic [W-1:0]      core_x1, core_y1, core_x2, core_y2;
    logic [W-1:0]      core_x3, core_y3;
    logic [FSIZE-1:0]  core_flags;
    logic              core_done;
    logic              rsp_valid, rsp_ready;
    logic [W-1:0]      rsp_x3, rsp_y3;
    logic [FSIZE-1:0]  rsp_flags;
    logic [TAGW-1:0]   rsp_tag;
    logic              rsp_timeout, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xfire_fpu_bkm_host #(.W(W), .TAGW(TAGW), .TMO(TMO), .TMW(TMW)) dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_format(cmd_format),
        .cmd_op(cmd_op), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2),
        .cmd_y2(cmd_y2), .cmd_tag(cmd_tag),
        .core_start(core_start), .core_format(core_format), .core_op(core_op),
        .core_x1(core_x1), .core_y1(core_y1), .core_x2(core_x2), .core_y2(core_y2),
        .core_x3(core_x3), .core_y3(core_y3), .core_flags(core_flags),
        .core_done(core_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_x3(rsp_x3),
        .rsp_y3(rsp_y3), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},      64'(busy), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_start"},     64'(core_start), 64'd0);
        chk({tag, "_rsp_x3"},    rsp_x3, 64'd0);
        chk({tag, "_rsp_y3"},    rsp_y3, 64'd0);
        chk({tag, "_rsp_misc"},  64'({rsp_flags, rsp_tag, rsp_timeout}), 64'd0);
        chk({tag, "_core_ops"},  core_x1 | core_y1 | core_x2 | core_y2, 64'd0);
        chk({tag, "_core_ctl"},  64'({core_op, core_format}), 64'd0);
    endtask

    // One command end to end. done_idx = WAIT cycle (0-based) on which the
    // emulated core raises done; >= TMO means it never does.
    task automatic run_txn(input int done_idx, input bit pause, input int hold);
        logic [W-1:0]      x1, y1, x2, y2, ex3, ey3;
        logic [FSIZE-1:0]  ef;
        logic [OPSIZE-1:0] op;
        logic [1:0]        fmt;
        logic [TAGW-1:0]   tag;
        bit                to, started, got, wp;
        int                starts, widx, exp_wait;
        to       = (done_idx >= TMO);
        exp_wait = to ? TMO : done_idx + 1;
        x1 = {$urandom, $urandom}; y1 = {$urandom, $urandom};
        x2 = {$urandom, $urandom}; y2 = {$urandom, $urandom};
        op = OPSIZE'($urandom); fmt = 2'($urandom); tag = TAGW'($urandom);
        ex3 = '0; ey3 = '0; ef = '0;
        starts = 0; widx = 0; started = 0; got = 0; wp = 0;

        @(negedge clk);
        cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2;
        cmd_op = op; cmd_format = fmt; cmd_tag = tag; cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_x1 = {$urandom, $urandom}; cmd_y1 = {$urandom, $urandom};
        cmd_tag = TAGW'($urandom);
        #1;
        chk("core_x1", core_x1, x1);
        chk("core_y1", core_y1, y1);
        chk("core_x2", core_x2, x2);
        chk("core_y2", core_y2, y2);
        chk("core_op_fmt", 64'({core_op, core_format}), 64'({op, fmt}));
        if (pause) begin
            enable = 1'b0;
            repeat (5) begin
                @(negedge clk); #1;
                chk("start_frozen", 64'({core_start, busy}), 64'b01);
            end
            enable = 1'b1;
        end
        for (int c = 0; c < 400 && !got; c++) begin
            #1;
            core_done  = 1'b0;
            core_x3    = {$urandom, $urandom};
            core_y3    = {$urandom, $urandom};
            core_flags = FSIZE'($urandom);
            if (rsp_valid) got = 1;
            else if (core_start) begin
                starts++;
                started = 1;
            end else if (started) begin
                if (pause && widx == 3 && !wp) begin
                    wp = 1;
                    enable = 1'b0;
                    repeat (5) begin
                        @(negedge clk); #1;
                        chk("wait_frozen", 64'({rsp_valid, core_start}), 64'd0);
                    end
                    enable = 1'b1;
                end
                if (widx == done_idx) begin
                    core_done = 1'b1;
                    ex3 = core_x3; ey3 = core_y3; ef = core_flags;
                end
                widx++;
            end
            if (!got) @(negedge clk);
        end
        core_done = 1'b0;
        chk("rsp_seen", 64'(got), 64'd1);
        chk("start_pulses", 64'(starts), 64'd1);
        chk("wait_cycles", 64'(widx), 64'(exp_wait));
        chk("rsp_x3", rsp_x3, ex3);
        chk("rsp_y3", rsp_y3, ey3);
        chk("rsp_flags_tag_to", 64'({rsp_flags, rsp_tag, rsp_timeout}), 64'({ef, tag, to}));
        chk("resp_cmd_ready", 64'({cmd_ready, busy}), 64'b01);
        for (int h = 0; h < hold; h++) begin
            core_done = to ? 1'b1 : 1'($urandom);
            core_x3   = {$urandom, $urandom};
            @(negedge clk); #1;
            chk("hold_valid", 64'({rsp_valid, cmd_ready}), 64'b10);
            chk("hold_x3", rsp_x3, ex3);
            chk("hold_misc", 64'({rsp_y3[7:0], rsp_flags, rsp_tag, rsp_timeout}),
                64'({ey3[7:0], ef, tag, to}));
        end
        core_done = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("back_to_idle", 64'({rsp_valid, busy, cmd_ready}), 64'b001);
        chk("core_x1_held", core_x1, x1);
    endtask

    // Launch a command and leave it sitting in WAIT.
    task automatic launch_to_wait();
        @(negedge clk);
        cmd_x1 = {$urandom, $urandom}; cmd_op = OPSIZE'($urandom | 1);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        arst = 1'b1; srst = 1'b0; enable = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_format = '0; cmd_op = '0; cmd_tag = '0;
        cmd_x1 = '0; cmd_y1 = '0; cmd_x2 = '0; cmd_y2 = '0;
        core_x3 = '0; core_y3 = '0; core_flags = '0; core_done = 1'b0;
        #1;
        chk_idle_zero("reset");
        repeat (3) @(negedge clk);
        arst = 1'b0;

        run_txn(9, 1'b0, 0);                         // basic op, done on 10th WAIT cycle
        run_txn($urandom_range(0, 12), 1'b0, 20);    // response backpressure
        run_txn(TMO + 5, 1'b0, 4);                   // timeout, then late done ignored
        run_txn(TMO - 1, 1'b0, 2);                   // done on the last watchdog cycle
        run_txn(7, 1'b1, 1);                         // enable pauses in START and WAIT

        launch_to_wait();
        #2 arst = 1'b1;
        #1 chk("arst_busy_pre", 64'(busy), 64'd0);
        chk_idle_zero("arst");
        @(negedge clk);
        arst = 1'b0;
        run_txn(3, 1'b0, 0);

        launch_to_wait();
        srst = 1'b1; enable = 1'b0;
        @(negedge clk); #1;
        chk_idle_zero("srst");
        srst = 1'b0; enable = 1'b1;
        run_txn(0, 1'b0, 1);

        for (int i = 0; i < 8; i++)
            run_txn($urandom_range(0, TMO + 3), 1'($urandom), $urandom_range(0, 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
